// File: rtl/i2c_target_regfile.sv
// ---------------------------------------------------------------------------
// i2c_target_regfile: I2C target exposing DEPTH 8-bit registers.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         DEPTH    = 64,
  parameter bit         AUTO_INC = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  state_t        state;
  logic          scl_q1, scl_s, scl_p;
  logic          sda_q1, sda_s, sda_p;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          phase;
  logic          ack_go;
  logic          rw;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_next;
  logic [7:0]    mem [DEPTH];

  logic          scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0]    byte_in;
  logic          reg_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q1 <= 1'b1;
      scl_s  <= 1'b1;
      scl_p  <= 1'b1;
      sda_q1 <= 1'b1;
      sda_s  <= 1'b1;
      sda_p  <= 1'b1;
    end else begin
      scl_q1 <= scl;
      scl_s  <= scl_q1;
      scl_p  <= scl_s;
      sda_q1 <= sda_in;
      sda_s  <= sda_q1;
      sda_p  <= sda_s;
    end
  end

  assign scl_rise = scl_s & ~scl_p;
  assign scl_fall = ~scl_s & scl_p;
  assign start_ev = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_ev  = scl_s & scl_p & ~sda_p & sda_s;
  assign byte_in  = {shift[6:0], sda_s};
  assign reg_ok   = ({1'b0, byte_in} < 9'(DEPTH));

  always_comb begin
    ptr_next = ptr;
    if (AUTO_INC) begin
      ptr_next = (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    end
  end

  // Bus conditions outrank bit edges; ACK states use phase to tell the fall
  // that opens the ACK slot from the fall that closes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sda_oe  <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= 8'h00;
      wr_data <= 8'h00;
      busy    <= 1'b0;
      shift   <= 8'h00;
      bit_cnt <= 3'd0;
      phase   <= 1'b0;
      ack_go  <= 1'b0;
      rw      <= 1'b0;
      ptr     <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      wr_en <= 1'b0;
      if (start_ev) begin
        state   <= ADDR;
        bit_cnt <= 3'd0;
        phase   <= 1'b0;
        sda_oe  <= 1'b0;
      end else if (stop_ev) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
        phase  <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ADDR, REG, WDATA: begin
            shift   <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              phase <= 1'b0;
              if (state == ADDR) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  rw     <= byte_in[0];
                  ack_go <= 1'b1;
                  busy   <= 1'b1;
                  state  <= ADDR_ACK;
                end else begin
                  state <= IGNORE;
                end
              end else if (state == REG) begin
                ack_go <= reg_ok;
                if (reg_ok) ptr <= byte_in[AW-1:0];
                state <= REG_ACK;
              end else begin
                mem[ptr] <= byte_in;
                wr_en    <= 1'b1;
                wr_addr  <= 8'(ptr);
                wr_data  <= byte_in;
                ptr      <= ptr_next;
                ack_go   <= 1'b1;
                state    <= WDATA_ACK;
              end
            end
          end
          RDATA: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              phase <= 1'b0;
              state <= RDATA_ACK;
            end
          end
          RDATA_ACK: begin
            if (phase && sda_s) state <= IGNORE;
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ADDR_ACK, REG_ACK, WDATA_ACK: begin
            if (!phase) begin
              sda_oe <= ack_go;
              phase  <= 1'b1;
            end else begin
              phase   <= 1'b0;
              bit_cnt <= 3'd0;
              if (state == ADDR_ACK && rw) begin
                shift  <= mem[ptr];
                sda_oe <= ~mem[ptr][7];
                ptr    <= ptr_next;
                state  <= RDATA;
              end else begin
                sda_oe <= 1'b0;
                if (state == ADDR_ACK)     state <= REG;
                else if (ack_go)           state <= WDATA;
                else                       state <= IGNORE;
              end
            end
          end
          RDATA: begin
            shift  <= {shift[6:0], 1'b0};
            sda_oe <= ~shift[6];
          end
          RDATA_ACK: begin
            if (!phase) begin
              sda_oe <= 1'b0;
              phase  <= 1'b1;
            end else begin
              phase   <= 1'b0;
              bit_cnt <= 3'd0;
              shift   <= mem[ptr];
              sda_oe  <= ~mem[ptr][7];
              ptr     <= ptr_next;
              state   <= RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_target_regfile.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_regfile: directed I2C master bench for i2c_target_regfile.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_i2c_target_regfile;

  localparam time Q = 50ns;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, wr_en, busy;
  logic [7:0] wr_addr, wr_data;

  int         n_checks = 0;
  int         n_pass = 0;
  int         wr_cnt = 0;
  logic [7:0] last_addr = 8'h00;
  logic [7:0] last_data = 8'h00;
  logic       oe_seen = 1'b0;
  logic       busy_seen = 1'b0;
  logic       ack;
  logic [7:0] rd;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target_regfile #(.DEV_ADDR(7'h50), .DEPTH(64), .AUTO_INC(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5ns clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt    = wr_cnt + 1;
      last_addr = wr_addr;
      last_data = wr_data;
    end
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    send_bits(b, 8);
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; a = sda_line; #Q; scl = 1'b0; #Q;
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    d = 8'h00;
    sda_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #Q; scl = 1'b1; #Q; d = {d[6:0], sda_line}; #Q; scl = 1'b0; #Q;
    end
    sda_m = master_ack; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    sda_m = 1'b1;
  endtask

  initial begin
    #22ns rst_n = 1'b1;
    #20ns;
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);

    // single write 0x3C to register 0x05
    i2c_start();
    send_byte(8'hA0, ack); check("wr_addr_ack", ack, 0);
    check("wr_busy", busy, 1);
    send_byte(8'h05, ack); check("wr_reg_ack", ack, 0);
    send_byte(8'h3C, ack); check("wr_data_ack", ack, 0);
    i2c_stop(); #Q;
    check("wr_count", wr_cnt, 1);
    check("wr_last_addr", last_addr, 8'h05);
    check("wr_last_data", last_data, 8'h3C);
    check("wr_busy_after_stop", busy, 0);

    // read back register 5 through a repeated START
    i2c_start();
    send_byte(8'hA0, ack); send_byte(8'h05, ack);
    i2c_start();
    send_byte(8'hA1, ack); check("rb_addr_ack", ack, 0);
    read_byte(1'b1, rd); check("rb_data", rd, 8'h3C);
    i2c_stop(); #Q;

    // register 1 = 0x77, then burst write 0x11,0x22 at 0x3E
    i2c_start();
    send_byte(8'hA0, ack); send_byte(8'h01, ack); send_byte(8'h77, ack);
    i2c_stop(); #Q;
    i2c_start();
    send_byte(8'hA0, ack); send_byte(8'h3E, ack);
    send_byte(8'h11, ack); send_byte(8'h22, ack); check("bw_ack2", ack, 0);
    i2c_stop(); #Q;
    check("bw_count", wr_cnt, 4);
    check("bw_last_addr", last_addr, 8'h3F);

    // burst read with wrap from 0x3F to 0x00
    i2c_start();
    send_byte(8'hA0, ack); send_byte(8'h3E, ack);
    i2c_start();
    send_byte(8'hA1, ack);
    read_byte(1'b0, rd); check("br_byte0", rd, 8'h11);
    read_byte(1'b0, rd); check("br_byte1", rd, 8'h22);
    read_byte(1'b1, rd); check("br_byte2_wrap", rd, 8'h00);
    i2c_stop(); #Q;
    // pointer left at 0x01 -> current-address read returns register 1
    i2c_start();
    send_byte(8'hA1, ack);
    read_byte(1'b1, rd); check("ptr_persist", rd, 8'h77);
    i2c_stop(); #Q;

    // address mismatch
    oe_seen = 1'b0; busy_seen = 1'b0;
    i2c_start();
    send_byte(8'hA2, ack); check("mm_addr_nack", ack, 1);
    send_byte(8'h05, ack); check("mm_byte_nack", ack, 1);
    i2c_stop(); #Q;
    check("mm_oe_never", oe_seen, 0);
    check("mm_busy_never", busy_seen, 0);
    check("mm_no_write", wr_cnt, 4);

    // register index out of range
    i2c_start();
    send_byte(8'hA0, ack); check("oor_addr_ack", ack, 0);
    send_byte(8'h40, ack); check("oor_reg_nack", ack, 1);
    send_byte(8'h55, ack); check("oor_data_nack", ack, 1);
    i2c_stop(); #Q;
    check("oor_no_write", wr_cnt, 4);

    // STOP after 4 data bits aborts the byte
    i2c_start();
    send_byte(8'hA0, ack); send_byte(8'h07, ack);
    send_bits(8'hF0, 4);
    i2c_stop(); #Q;
    check("abort_no_write", wr_cnt, 4);
    check("abort_busy", busy, 0);
    i2c_start();
    send_byte(8'hA0, ack); send_byte(8'h07, ack);
    send_byte(8'h99, ack); check("post_abort_ack", ack, 0);
    i2c_stop(); #Q;
    check("post_abort_count", wr_cnt, 5);
    check("post_abort_addr", last_addr, 8'h07);
    check("post_abort_data", last_data, 8'h99);

    // reset while the address ACK is driven
    i2c_start();
    send_bits(8'hA0, 8);
    sda_m = 1'b1; #Q; scl = 1'b1; #Q;
    check("ack_driven", sda_oe, 1);
    rst_n = 1'b0;
    #1ns;
    check("rst_async_oe", sda_oe, 0);
    check("rst_async_busy", busy, 0);
    #20ns rst_n = 1'b1;
    #Q; scl = 1'b0; #Q;
    i2c_stop(); #Q;
    i2c_start();
    send_byte(8'hA0, ack); send_byte(8'h05, ack);
    i2c_start();
    send_byte(8'hA1, ack); check("post_rst_ack", ack, 0);
    read_byte(1'b1, rd); check("post_rst_cleared", rd, 8'h00);
    i2c_stop(); #Q;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
